output_drain: RTL and testbench

Read-side sequencer for the output buffer. It walks the partial-output memory over `out_sel_o`/`out_dat_i` and streams each entry to downstream logic over a valid/ready interface. Each beat carries the entry's index and a last flag, and the block pulses `done_o` when the drain completes. It sits between the output buffer's read port and the write-back/DMA path, and is started once accumulation for a tile has finished.

---
 rtl/output_drain_if.sv | 14 +
 rtl/output_drain.sv | 80 ++++++++
 tb/tb_output_drain.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/output_drain_if.sv
// output_drain_if: valid/ready beat stream carrying buffer entries with index and last flag
interface output_drain_if #(
  parameter int BUF_SIZE = 32,
  parameter int BUF_NUM  = 32
);
  localparam int AW = $clog2(BUF_NUM);
  logic                m_val_o;
  logic                m_rdy_i;
  logic [BUF_SIZE-1:0] m_dat_o;
  logic [AW-1:0]       m_idx_o;
  logic                m_last_o;
  modport master (output m_val_o, m_dat_o, m_idx_o, m_last_o, input m_rdy_i);
  modport slave  (input m_val_o, m_dat_o, m_idx_o, m_last_o, output m_rdy_i);
endinterface

// File: rtl/output_drain.sv
// output_drain: walks the output buffer and streams its entries; define OUTPUT_DRAIN_RELU_EN to clamp negative entries to zero
module output_drain #(
  parameter int BUF_SIZE = 32,
  parameter int BUF_NUM  = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [$clog2(BUF_NUM)-1:0] cnt_i,
  input  logic                       abort_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [$clog2(BUF_NUM)-1:0] out_sel_o,
  input  logic [BUF_SIZE-1:0]        out_dat_i,
  output_drain_if.master             m
);
  localparam int AW = $clog2(BUF_NUM);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e              state_q, state_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d, idx_q, idx_d;
  logic [AW:0]         rem_q, rem_d;
  logic                val_q, val_d, last_q, last_d;
  logic [BUF_SIZE-1:0] dat_q, dat_d, load_dat;
  logic                load, hs, final_load;

`ifdef OUTPUT_DRAIN_RELU_EN
  assign load_dat = out_dat_i[BUF_SIZE-1] ? '0 : out_dat_i;
`else
  assign load_dat = out_dat_i;
`endif

  // state register and one-entry output register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      rem_q    <= '0;
      val_q    <= 1'b0;
      dat_q    <= '0;
      idx_q    <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      rem_q    <= rem_d;
      val_q    <= val_d;
      dat_q    <= dat_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
    end
  end

  // abort beats start and handshake; a load refills the output slot whenever it is empty or draining
  always_comb begin
    hs         = val_q && m.m_rdy_i;
    load       = !abort_i && state_q == RUN && rem_q != '0 && (!val_q || m.m_rdy_i);
    final_load = rem_q == (AW+1)'(1);
    state_d    = abort_i                       ? IDLE :
                 (state_q == IDLE && start_i)  ? RUN  :
                 (state_q == RUN && hs && last_q) ? DONE :
                 (state_q == DONE)             ? IDLE : state_q;
    rem_d      = abort_i                      ? '0 :
                 (state_q == IDLE && start_i) ? (cnt_i == '0 ? (AW+1)'(BUF_NUM) : {1'b0, cnt_i}) :
                 load                         ? rem_q - 1'b1 : rem_q;
    rd_ptr_d   = (state_d == IDLE || state_q == IDLE) ? '0 :
                 (load && !final_load)               ? rd_ptr_q + 1'b1 : rd_ptr_q;
    val_d      = abort_i ? 1'b0 : load ? 1'b1 : hs ? 1'b0 : val_q;
    dat_d      = load ? load_dat : dat_q;
    idx_d      = load ? rd_ptr_q : idx_q;
    last_d     = state_d == IDLE ? 1'b0 : load ? final_load : last_q;
  end

  assign busy_o     = state_q != IDLE;
  assign done_o     = state_q == DONE;
  assign out_sel_o  = rd_ptr_q;
  assign m.m_val_o  = val_q;
  assign m.m_dat_o  = dat_q;
  assign m.m_idx_o  = idx_q;
  assign m.m_last_o = last_q;
endmodule

// File: tb/tb_output_drain.sv
// tb_output_drain: table-driven and randomized drains checked against a beat-queue model
module tb_output_drain;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [4:0]  cnt_i = '0;
  logic        abort_i = 1'b0;
  logic        busy_o, done_o;
  logic [4:0]  out_sel_o;
  logic [31:0] out_dat_i;
  logic [31:0] mem [32];
  logic [31:0] got_dat [32];
  int          checks = 0;
  int          failures = 0;

  output_drain_if #(.BUF_SIZE(32), .BUF_NUM(32)) mi ();

  output_drain #(.BUF_SIZE(32), .BUF_NUM(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .cnt_i(cnt_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .out_sel_o(out_sel_o), .out_dat_i(out_dat_i), .m(mi)
  );

  assign out_dat_i = mem[out_sel_o];

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int mode;
    int exp_n;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_dat(input logic [31:0] d);
`ifdef OUTPUT_DRAIN_RELU_EN
    return $signed(d) < 0 ? 32'd0 : d;
`else
    return d;
`endif
  endfunction

  function automatic logic rdy_for(input int mode, input int c);
    return mode == 0 ? 1'b1 : mode == 1 ? (c % 3 == 0) : 1'($urandom_range(0, 1));
  endfunction

  task automatic run_drain(input int cnt, input int mode, input bit poke, output int nhs);
    logic [31:0] exp_dat[$];
    int          exp_idx[$];
    int          n, c, last_hs, done_c, ndone;
    logic        pv, pr, pl;
    logic [31:0] pd;
    logic [4:0]  pi;
    bit          fin;
    n = (cnt == 0) ? 32 : cnt;
    c = 0; last_hs = -1; done_c = -1; ndone = 0; nhs = 0; fin = 0;
    pv = 0; pr = 0; pl = 0; pd = '0; pi = '0;
    for (int i = 0; i < n; i++) begin
      exp_dat.push_back(model_dat(mem[i]));
      exp_idx.push_back(i);
    end
    @(posedge clk); #1;
    start_i = 1'b1;
    cnt_i = cnt[4:0];
    mi.m_rdy_i = rdy_for(mode, 0);
    while (!fin && c < 400) begin
      @(posedge clk); #1;
      c++;
      start_i = poke && c == 3;
      if (poke) cnt_i = 5'd5;
      mi.m_rdy_i = rdy_for(mode, c);
      if (c == 1) begin
        chk("busy_run", busy_o, 1);
        chk("sel_start", out_sel_o, 0);
      end
      if (pv && !pr) begin
        chk("hold_val", mi.m_val_o, 1);
        chk("hold_dat", mi.m_dat_o, pd);
        chk("hold_idx", mi.m_idx_o, pi);
        chk("hold_last", mi.m_last_o, pl);
      end
      if (done_o) begin
        ndone++;
        done_c = c;
        chk("done_time", c, last_hs + 1);
        if (mode == 0) chk("done_abs", c, 2 + n);
      end
      if (done_c >= 0 && c == done_c + 1) begin
        chk("busy_end", busy_o, 0);
        chk("sel_idle", out_sel_o, 0);
        fin = 1;
      end
      if (mi.m_val_o && mi.m_rdy_i && !fin) begin
        if (exp_idx.size() == 0) chk("extra_beat", 1, 0);
        else begin
          chk("beat_idx", mi.m_idx_o, exp_idx.pop_front());
          chk("beat_dat", mi.m_dat_o, exp_dat.pop_front());
          chk("beat_last", mi.m_last_o, exp_idx.size() == 0);
          if (mode == 0) chk("beat_time", c, 2 + nhs);
          got_dat[nhs] = mi.m_dat_o;
          nhs++;
          last_hs = c;
        end
      end
      pv = mi.m_val_o; pr = mi.m_rdy_i; pd = mi.m_dat_o; pi = mi.m_idx_o; pl = mi.m_last_o;
    end
    chk("drain_finished", fin, 1);
    chk("done_count", ndone, 1);
    start_i = 1'b0;
  endtask

  initial begin
    vec_t tv[6];
    int   nhs;
    bit   seen;
    mi.m_rdy_i = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 32'(i * 3);
    tv[0] = '{cnt: 0,  mode: 0, exp_n: 32};
    tv[1] = '{cnt: 4,  mode: 1, exp_n: 4};
    tv[2] = '{cnt: 1,  mode: 0, exp_n: 1};
    tv[3] = '{cnt: 7,  mode: 2, exp_n: 7};
    tv[4] = '{cnt: 31, mode: 2, exp_n: 31};
    tv[5] = '{cnt: 2,  mode: 1, exp_n: 2};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_sel", out_sel_o, 0);
    chk("rst_val", mi.m_val_o, 0);
    chk("rst_dat", mi.m_dat_o, 0);
    chk("rst_idx", mi.m_idx_o, 0);
    chk("rst_last", mi.m_last_o, 0);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      run_drain(tv[i].cnt, tv[i].mode, 1'b0, nhs);
      chk("vec_beats", nhs, tv[i].exp_n);
    end

    run_drain(6, 0, 1'b1, nhs);
    chk("ignored_start_beats", nhs, 6);

    @(posedge clk); #1;
    start_i = 1'b1; cnt_i = 5'd8; mi.m_rdy_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int i = 0; i < 20 && !(mi.m_val_o && mi.m_idx_o == 5'd2); i++) begin
      @(posedge clk); #1;
    end
    chk("abort_reach_idx2", mi.m_val_o && mi.m_idx_o == 5'd2, 1);
    abort_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0; start_i = 1'b0;
    chk("abort_val", mi.m_val_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_last", mi.m_last_o, 0);
    chk("abort_sel", out_sel_o, 0);
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done_o || busy_o) seen = 1;
    end
    chk("abort_quiet", seen, 0);

    @(posedge clk); #1;
    start_i = 1'b1; cnt_i = 5'd0; mi.m_rdy_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int i = 0; i < 20 && !(mi.m_val_o && mi.m_idx_o == 5'd5); i++) begin
      @(posedge clk); #1;
    end
    chk("reset_reach_idx5", mi.m_val_o && mi.m_idx_o == 5'd5, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_done", done_o, 0);
    chk("arst_sel", out_sel_o, 0);
    chk("arst_val", mi.m_val_o, 0);
    chk("arst_dat", mi.m_dat_o, 0);
    chk("arst_idx", mi.m_idx_o, 0);
    chk("arst_last", mi.m_last_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("arst_no_done", done_o, 0);
    run_drain(3, 0, 1'b0, nhs);
    chk("post_reset_beats", nhs, 3);

    mem[0] = 32'h0000_0005;
    mem[1] = 32'hFFFF_FFFB;
    run_drain(2, 0, 1'b0, nhs);
    chk("relu_pos", got_dat[0], 32'h5);
`ifdef OUTPUT_DRAIN_RELU_EN
    chk("relu_neg", got_dat[1], 32'h0);
`else
    chk("relu_neg", got_dat[1], 32'hFFFF_FFFB);
`endif

    repeat (8) begin
      int rc;
      int rm;
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      rc = $urandom_range(0, 31);
      rm = $urandom_range(0, 2);
      run_drain(rc, rm, 1'b0, nhs);
      chk("rand_beats", nhs, rc == 0 ? 32 : rc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
